// File: rtl/secded_mem_sequencer_if.sv
// Memory and decoder handshake bundle between the SECDED sequencer and its neighbours.
// The sequencer side takes the master modport; memory/decoder models take the slave modport.
interface secded_mem_sequencer_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [15:0]   dec_word;
  logic          dec_start;
  logic          dec_valid;
  logic [15:0]   dec_result;

  modport master (
    output mem_addr, mem_wen, mem_wdata, dec_word, dec_start,
    input  mem_rdata, dec_valid, dec_result
  );

  modport slave (
    input  mem_addr, mem_wen, mem_wdata, dec_word, dec_start,
    output mem_rdata, dec_valid, dec_result
  );
endinterface

// File: rtl/secded_mem_sequencer.sv
// Walks NUM_WORDS byte-pair codewords through an external SECDED decoder and
// writes each 16-bit result back as two bytes, tallying single/double errors.
module secded_mem_sequencer #(
  parameter int SRC_BASE    = 30,
  parameter int DST_BASE    = 0,
  parameter int NUM_WORDS   = 15,
  parameter int AW          = 8,
  parameter int DEC_TIMEOUT = 16,
  parameter int CW          = $clog2(NUM_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  secded_mem_sequencer_if.master bus,
  output logic                  done,
  output logic [CW-1:0]         n_single,
  output logic [CW-1:0]         n_double,
  output logic                  timeout
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TW = $clog2(DEC_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(DEC_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_START, S_RD_LO, S_RD_HI, S_CAP, S_DREQ, S_DWAIT, S_WR_LO, S_WR_HI, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [15:0]   word;
  logic [15:0]   result;
  logic [TW-1:0] wait_cnt;

  function automatic logic [AW-1:0] byte_addr(input int base, input logic [IW-1:0] k,
                                               input logic hi);
    return AW'(base + 2 * int'(k) + int'(hi));
  endfunction

  assign bus.dec_word = word;

  always_comb begin
    state_nxt     = state;
    bus.mem_addr  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = '0;
    bus.dec_start = 1'b0;
    done          = 1'b0;
    case (state)
      S_START: state_nxt = S_RD_LO;
      S_RD_LO: begin
        bus.mem_addr = byte_addr(SRC_BASE, idx, 1'b0);
        state_nxt    = S_RD_HI;
      end
      S_RD_HI: begin
        bus.mem_addr = byte_addr(SRC_BASE, idx, 1'b1);
        state_nxt    = S_CAP;
      end
      S_CAP:   state_nxt = S_DREQ;
      S_DREQ: begin
        bus.dec_start = 1'b1;
        state_nxt     = bus.dec_valid ? S_WR_LO : S_DWAIT;
      end
      S_DWAIT: begin
        if (bus.dec_valid || wait_cnt == WAIT_LAST) state_nxt = S_WR_LO;
      end
      S_WR_LO: begin
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = byte_addr(DST_BASE, idx, 1'b0);
        bus.mem_wdata = result[7:0];
        state_nxt     = S_WR_HI;
      end
      S_WR_HI: begin
        bus.mem_wen   = 1'b1;
        bus.mem_addr  = byte_addr(DST_BASE, idx, 1'b1);
        bus.mem_wdata = result[15:8];
        state_nxt     = (idx == LAST_IDX) ? S_DONE : S_RD_LO;
      end
      S_DONE:  done = 1'b1;
      default: state_nxt = S_START;
    endcase
  end

  // Reset doubles as the start request, so every piece of run state is cleared here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_START;
      idx      <= '0;
      word     <= '0;
      result   <= '0;
      n_single <= '0;
      n_double <= '0;
      timeout  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_RD_HI: word[7:0] <= bus.mem_rdata;
        S_CAP: begin
          word[15:8] <= bus.mem_rdata;
          wait_cnt   <= '0;
        end
        S_DREQ: if (bus.dec_valid) result <= bus.dec_result;
        S_DWAIT: begin
          // A hung decoder is reported as a double error so the word is still written.
          if (bus.dec_valid) begin
            result <= bus.dec_result;
          end else if (wait_cnt == WAIT_LAST) begin
            result  <= 16'h8000;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WR_LO: begin
          n_single <= n_single + CW'(!result[15] && result[14]);
          n_double <= n_double + CW'(result[15]);
        end
        S_WR_HI: if (idx != LAST_IDX) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_mem_sequencer.sv
// Directed bench for secded_mem_sequencer: byte memory and programmable decoder
// models, table-driven result vectors and hand-written timeout/reset sequences.
module tb_secded_mem_sequencer;
  localparam int AW  = 8;
  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  secded_mem_sequencer_if #(.AW(AW)) bus ();
  logic          done, timeout;
  logic [CW-1:0] n_single, n_double;

  secded_mem_sequencer dut (
    .clk(clk), .reset(reset), .bus(bus),
    .done(done), .n_single(n_single), .n_double(n_double), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  // Byte memory with one-cycle read latency and a bench load port.
  logic [7:0]    mem [0:255];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  int            wr_cnt = 0;
  int            wr_in_rst = 0;
  logic [AW-1:0] first_addr = '0;
  always @(posedge clk) begin
    if (reset) begin
      wr_cnt = 0;
      if (bus.mem_wen) wr_in_rst++;
    end else if (bus.mem_wen) begin
      if (wr_cnt == 0) first_addr = bus.mem_addr;
      wr_cnt++;
    end
  end

  // Decoder model: per-word response delay (0 = same cycle as start, 255 = never).
  logic [7:0]  dly     [0:15];
  logic        ovr_en  [0:15];
  logic [15:0] ovr_val [0:15];
  logic [4:0]  dec_cnt;
  logic [3:0]  cur_w, w_now;
  logic        busy, late_en;
  logic [7:0]  ctr;
  logic [15:0] seen_w0;

  function automatic logic [15:0] f(input logic [15:0] c);
    return {c[15:14], 3'b000, c[10:0] ^ 11'h2A5};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      dec_cnt <= '0;
      cur_w   <= '0;
      busy    <= 1'b0;
      ctr     <= '0;
    end else if (bus.dec_start) begin
      if (dec_cnt == 5'd0) seen_w0 <= bus.dec_word;
      cur_w   <= dec_cnt[3:0];
      dec_cnt <= dec_cnt + 5'd1;
      busy    <= (dly[dec_cnt[3:0]] != 8'd0);
      ctr     <= 8'd1;
    end else if (busy) begin
      if (ctr == dly[cur_w]) busy <= 1'b0;
      ctr <= ctr + 8'd1;
    end
  end

  assign w_now          = bus.dec_start ? dec_cnt[3:0] : cur_w;
  assign bus.dec_valid  = (late_en && bus.mem_wen && bus.mem_addr == AW'(DST + 4))
                        || (bus.dec_start && dly[w_now] == 8'd0)
                        || (busy && !bus.dec_start && ctr == dly[w_now]);
  assign bus.dec_result = ovr_en[w_now] ? ovr_val[w_now] : f(bus.dec_word);

  logic [15:0] cw      [0:NW-1];
  logic [15:0] exp_res [0:NW-1];

  typedef struct {
    logic [15:0] cw;
    logic [15:0] res;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
  } vec_t;
  vec_t vt [0:NW-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_byte(input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = AW'(a); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_run();
    reset = 1'b1;
    for (int i = 0; i < NW; i++) begin
      load_byte(SRC + 2 * i, cw[i][7:0]);
      load_byte(SRC + 2 * i + 1, cw[i][15:8]);
    end
    for (int i = 0; i < 2 * NW; i++) load_byte(DST + i, 8'hEE);
  endtask

  task automatic default_setup(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      dly[i] = 8'd0; ovr_en[i] = 1'b0; ovr_val[i] = '0;
    end
    for (int i = 0; i < NW; i++) begin
      cw[i] = 16'($urandom) & mask;
      exp_res[i] = f(cw[i]);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_nsingle"}, 32'(n_single), 32'd0);
    chk({tag, "_ndouble"}, 32'(n_double), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_wen"}, 32'(bus.mem_wen), 32'd0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_start"}, 32'(bus.dec_start), 32'd0);
  endtask

  task automatic run(output int cyc);
    reset = 1'b0;
    cyc = 0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s_lo%0d", tag, i), 32'(mem[DST + 2 * i]), 32'(exp_res[i][7:0]));
      chk($sformatf("%s_hi%0d", tag, i), 32'(mem[DST + 2 * i + 1]), 32'(exp_res[i][15:8]));
    end
  endtask

  task automatic check_counts(input string tag);
    int s, d;
    s = 0; d = 0;
    for (int i = 0; i < NW; i++) begin
      if (exp_res[i][15]) d++;
      else if (exp_res[i][14]) s++;
    end
    chk({tag, "_nsingle"}, 32'(n_single), 32'(s));
    chk({tag, "_ndouble"}, 32'(n_double), 32'(d));
  endtask

  int cyc, n;

  initial begin
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; late_en = 1'b0;
    vt[0]  = '{16'h1234, 16'h0011, 8'h11, 8'h00};
    vt[1]  = '{16'h2345, 16'h4001, 8'h01, 8'h40};
    vt[2]  = '{16'h3456, 16'h8077, 8'h77, 8'h80};
    vt[3]  = '{16'h4567, 16'h0022, 8'h22, 8'h00};
    vt[4]  = '{16'h5678, 16'h4002, 8'h02, 8'h40};
    vt[5]  = '{16'h6789, 16'hC099, 8'h99, 8'hC0};
    vt[6]  = '{16'h789A, 16'h0033, 8'h33, 8'h00};
    vt[7]  = '{16'h89AB, 16'h4003, 8'h03, 8'h40};
    vt[8]  = '{16'h9ABC, 16'h4004, 8'h04, 8'h40};
    vt[9]  = '{16'hABCD, 16'h0044, 8'h44, 8'h00};
    vt[10] = '{16'hBCDE, 16'h8088, 8'h88, 8'h80};
    vt[11] = '{16'hCDEF, 16'h4005, 8'h05, 8'h40};
    vt[12] = '{16'hDEF0, 16'hC0AA, 8'hAA, 8'hC0};
    vt[13] = '{16'hEF01, 16'h0055, 8'h55, 8'h00};
    vt[14] = '{16'hF012, 16'h4006, 8'h06, 8'h40};
    @(negedge clk);

    // Run A: zero-wait decoder, random codewords.
    default_setup(16'hFFFF);
    load_run();
    check_idle("A_rst");
    run(cyc);
    chk("A_cycles", 32'(cyc), 32'd91);
    repeat (3) @(negedge clk);
    chk("A_done_held", 32'(done), 32'd1);
    chk("A_writes", 32'(wr_cnt), 32'd30);
    chk("A_first_addr", 32'(first_addr), 32'(DST));
    check_mem("A");
    check_counts("A");
    chk("A_timeout", 32'(timeout), 32'd0);

    // Run B: delayed word 0, hung decoder on word 2 with a late valid in its WR_LO.
    default_setup(16'h3FFF);
    cw[0] = 16'hA5C3; dly[0] = 8'd3; ovr_en[0] = 1'b1; ovr_val[0] = 16'h4123;
    cw[2] = 16'hFFFF; dly[2] = 8'd255;
    exp_res[0] = 16'h4123; exp_res[2] = 16'h8000;
    load_run();
    late_en = 1'b1;
    run(cyc);
    late_en = 1'b0;
    chk("B_cycles", 32'(cyc), 32'd110);
    chk("B_dec_word0", 32'(seen_w0), 32'hA5C3);
    chk("B_byte0", 32'(mem[DST]), 32'h23);
    chk("B_byte1", 32'(mem[DST + 1]), 32'h41);
    chk("B_byte4", 32'(mem[DST + 4]), 32'h00);
    chk("B_byte5", 32'(mem[DST + 5]), 32'h80);
    check_mem("B");
    chk("B_nsingle", 32'(n_single), 32'd1);
    chk("B_ndouble", 32'(n_double), 32'd1);
    chk("B_timeout", 32'(timeout), 32'd1);
    chk("B_writes", 32'(wr_cnt), 32'd30);

    // Run C: reset pulse while word 7 is waiting on the decoder.
    default_setup(16'hFFFF);
    dly[2] = 8'd255; exp_res[2] = 16'h8000;
    dly[7] = 8'd5;
    load_run();
    reset = 1'b0;
    n = 0;
    while (!(bus.dec_start && dec_cnt == 5'd7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("C_reach_w7", 32'(bus.dec_start && dec_cnt == 5'd7), 32'd1);
    @(negedge clk);
    chk("C_timeout_pre", 32'(timeout), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("C_rst");
    @(negedge clk);
    run(cyc);
    chk("C_cycles", 32'(cyc), 32'd112);
    chk("C_wr_in_rst", 32'(wr_in_rst), 32'd0);
    chk("C_writes", 32'(wr_cnt), 32'd30);
    chk("C_first_addr", 32'(first_addr), 32'(DST));
    check_mem("C");
    check_counts("C");
    chk("C_timeout", 32'(timeout), 32'd1);

    // Run D: table of decoder results with mixed error flags.
    default_setup(16'hFFFF);
    for (int i = 0; i < NW; i++) begin
      cw[i] = vt[i].cw; ovr_en[i] = 1'b1; ovr_val[i] = vt[i].res;
    end
    load_run();
    run(cyc);
    chk("D_cycles", 32'(cyc), 32'd91);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("D_lo%0d", i), 32'(mem[DST + 2 * i]), 32'(vt[i].exp_lo));
      chk($sformatf("D_hi%0d", i), 32'(mem[DST + 2 * i + 1]), 32'(vt[i].exp_hi));
    end
    chk("D_nsingle", 32'(n_single), 32'd6);
    chk("D_ndouble", 32'(n_double), 32'd4);
    chk("D_timeout", 32'(timeout), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secded_mem_sequencer.md
Name: secded_mem_sequencer

Overview:
- Hardware sequencer for the program-2 Hamming SECDED correction pass.
- Walks NUM_WORDS 16-bit codewords stored as byte pairs in byte-wide data memory and hands each codeword to an external decoder through a start/valid handshake.
- Writes each 16-bit decoder result back as two bytes, counts single and double errors, and raises done.
- Sits in top_level between the data memory and the decoder datapath; reset acts as the start request.

Parameters:
SRC_BASE, 30, byte address of the low byte of codeword 0; codeword i low byte at SRC_BASE+2i, high byte at SRC_BASE+2i+1
DST_BASE, 0, byte address of the low byte of result 0; same pairing as SRC_BASE
NUM_WORDS, 15, number of codewords processed per run
AW, 8, memory address width
DEC_TIMEOUT, 16, maximum DWAIT cycles before the decoder is declared hung
CW, $clog2(NUM_WORDS+1), width of the error counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high; also the start request
done  out  1  run complete; held high until the next reset
mem_addr  out  AW  memory byte address
mem_wen  out  1  memory write enable
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data; valid the cycle after mem_addr is presented
dec_word  out  16  codeword to the decoder; held stable from DREQ through DWAIT
dec_start  out  1  one-cycle decode request
dec_valid  in  1  decoder result valid
dec_result  in  16  decoder result; bit15=double error, bit14=single error, bits[10:0]=data
n_single  out  CW  count of results with bit15=0 and bit14=1
n_double  out  CW  count of double errors, including timeouts
timeout  out  1  sticky; set if any decode timed out

Behaviour:
- Reset: any edge with reset=1 sets state=START and clears the word index i, captured word, result register, counters, timeout flag and wait counter. Mid-run reset abandons the run; no further writes occur.
- While in START, done/mem_wen/dec_start are 0 and mem_addr=0.
- mem_addr, mem_wen, mem_wdata, dec_start and done are combinational decodes of state/i/result. dec_word is registered.
- States:
  - START: leave to RD_LO on the first edge with reset=0.
  - RD_LO: mem_addr=SRC_BASE+2i.
  - RD_HI: mem_addr=SRC_BASE+2i+1; capture mem_rdata into word[7:0].
  - CAP: capture mem_rdata into word[15:8].
  - DREQ: dec_start=1. If dec_valid=1 in this cycle, capture the result and go to WR_LO; else go to DWAIT.
  - DWAIT: wait counter increments each cycle. On dec_valid, capture dec_result and go to WR_LO. If the counter reaches DEC_TIMEOUT with no valid, the result becomes 16'h8000, timeout<=1, and go to WR_LO.
  - WR_LO: mem_wen=1, mem_addr=DST_BASE+2i, mem_wdata=result[7:0]. Counter update happens here, once per word.
  - WR_HI: mem_wen=1, mem_addr=DST_BASE+2i+1, mem_wdata=result[15:8]. If i==NUM_WORDS-1, go to DONE; else i<=i+1 and go to RD_LO.
  - DONE: done=1, no memory activity; stay until reset.
- dec_valid outside DREQ/DWAIT is ignored, including a late valid after a timeout.
- The wait counter clears on entry to DREQ.
- Latency with a zero-wait decoder: 6 cycles per word. done is first high 6*NUM_WORDS+1 cycles after the first START cycle with reset=0 (91 for defaults). Each DWAIT cycle adds 1.
- Exactly two writes per word, low byte first. Reads never overlap writes.
- Counters cannot overflow given CW; no wrap logic is required.

Test Plan:
- Zero-wait model decoder, 15 random codewords at bytes 30..59 -> bytes 0..29 hold the model decoder outputs; done first high exactly 91 cycles after the first START cycle with reset=0; 30 writes total.
- Codeword 16'hA5C3 at word 0, decoder returning 16'h4123 after 3 DWAIT cycles -> byte0=8'h23, byte1=8'h41; n_single=1; total cycle count +3.
- Decoder never asserting dec_valid for word 2 -> after 16 DWAIT cycles bytes 4/5 = 8'h00/8'h80; timeout=1; n_double incremented; remaining words processed normally.
- Late dec_valid pulse during WR_LO of word 2 -> ignored; word 3 result unaffected.
- Reset asserted for 2 cycles during DWAIT of word 7 -> no writes while reset is high; run restarts at word 0; done, counters and timeout cleared; final memory correct.
- Results mixing 8'h00/8'h40/8'h80/8'hC0 upper bytes (5/6/2/2 words) -> n_single=6, n_double=4.
